axis_traffic_endpoint: RTL and testbench
========================================

AXIS_TRAFFIC_ENDPOINT -- requirements
Module: axis_traffic_endpoint

Interface
REQ-001 SHALL have parameter TDataWidth, default 32: AXIS tdata width; minimum 16.
REQ-002 SHALL have parameter TIdWidth, default 2: tid width.
REQ-003 SHALL have parameter TDestWidth, default 4: tdest width.
REQ-004 SHALL have parameter NumberOfStreams, default 4: tid values used, round-robin; 1..2**TIdWidth.
REQ-005 SHALL have parameter MaxPacketLength, default 16: maximum beats per packet.
REQ-006 SHALL have port clk_axis_i, input, 1: single clock; all logic rising-edge.
REQ-007 SHALL have port rst_axis_i, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port start_i, input, 1: one-cycle pulse that launches a generation run.
REQ-009 SHALL have port packet_count_i, input, 16: packets per run, sampled at start.
REQ-010 SHALL have port packet_length_i, input, clog2(MaxPacketLength+1): beats per packet, sampled at start.
REQ-011 SHALL have port dest_i, input, TDestWidth: tdest for the run, sampled at start.
REQ-012 SHALL have ports m_axis_tvalid/tready/tdata/tlast/tid/tdest: Manager AXIS, widths 1/1/TDataWidth/1/TIdWidth/TDestWidth.
REQ-013 SHALL have ports s_axis_tvalid/tready/tdata/tlast/tid/tdest: Subordinate AXIS, same widths.
REQ-014 SHALL have port busy_o, output, 1: high while a run is in progress.
REQ-015 SHALL have port tx_done_o, output, 1: one-cycle pulse after the last tx beat handshakes.
REQ-016 SHALL have ports rx_packets_o and rx_errors_o, output, 32 each: saturating receive counters.

Function
REQ-017 Generator FSM SHALL have states IDLE, SEND, DONE.
- IDLE->SEND on start_i, only when packet_count_i!=0 and packet_length_i in 1..MaxPacketLength; otherwise start_i is ignored.
- SEND->DONE on the tlast handshake of the final packet.
- DONE->IDLE after exactly one cycle; tx_done_o is high only in DONE.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 m_axis_tvalid SHALL assert the cycle after SEND is entered and stay high until the run ends, with no bubbles.
REQ-020 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis payload signals SHALL hold stable.
REQ-021 Packet k of a run (k from 0) SHALL use tid = k mod NumberOfStreams; tdest = sampled dest_i.
REQ-022 tdata[15:0] SHALL be the per-tid 16-bit sequence counter; it increments on every handshake of that tid, wraps 0xFFFF->0, and persists across runs.
REQ-023 tdata[TDataWidth-1:16] SHALL be the bitwise inverse of the zero-extended sequence counter (self-check pattern).
REQ-024 tlast SHALL be 1 on beat packet_length-1 of each packet; for length 1, every beat has tlast=1.
REQ-025 s_axis_tready SHALL be constantly 1 after reset release.
REQ-026 Checker SHALL hold a per-tid 16-bit expected counter, reset to 0.
- Each s_axis handshake compares tdata[15:0] and the upper pattern against expected[tid].
- On mismatch, rx_errors_o increments and expected[tid] resyncs to received value +1.
- On match, expected[tid] increments with wrap.
REQ-027 rx_packets_o SHALL increment on each handshake with tlast=1; both counters saturate at 0xFFFFFFFF.
REQ-028 Generator and checker SHALL run concurrently and independently, including loopback m_axis->s_axis.

Reset
REQ-029 Reset SHALL force: FSM IDLE; m_axis_tvalid, tlast, busy_o, tx_done_o = 0; tdata, tid, tdest = 0; s_axis_tready = 0; all sequence and expected counters and rx counters = 0.
REQ-030 Reset asserted mid-packet SHALL abort the run immediately, with no completion pulse after release.

Structure
REQ-031 The state enum and the 16-bit sequence-field width constant SHALL reside in shared package axis_traffic_pkg.
REQ-032 The checker SHALL be a sub-module axis_traffic_checker; the generator SHALL stay in the top.

Verification
REQ-033 Loopback test: packet_count=4, length=3, NumberOfStreams=4, tready=1.
- Required: 12 beats; tids 0,1,2,3; tlast on beats 2/5/8/11; rx_packets=4, rx_errors=0; tx_done one cycle after beat 11.
REQ-034 Backpressure test: tready low for 5 cycles mid-packet.
- Required: payload held stable; no beat lost or duplicated; rx_errors=0.
REQ-035 Corruption test: inject tdata[15:0]=0x0005 when expected[tid]=0x0002.
- Required: rx_errors=1; the next beat with 0x0006 is accepted without error.
REQ-036 Wrap test: run 65537 beats on tid 0.
- Required: counter wraps 0xFFFF->0x0000 with no error.
REQ-037 Illegal start test: start with length=0, then start with count=0.
- Required: busy_o stays 0 and no tvalid is driven.
REQ-038 Mid-packet reset test: assert reset at beat 2 of 5, release, then start again.
- Required: outputs match REQ-029; the new run begins at tdata[15:0]=0.

Source files
------------

// File: rtl/axis_traffic_pkg.sv
// Shared types and constants for the AXI-Stream traffic generator/checker pair.
package axis_traffic_pkg;

   localparam int SeqWidth = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } gen_state_e;

endpackage

// File: rtl/axis_traffic_endpoint_if.sv
// AXI-Stream bundle used for both the generated (manager) and received (subordinate) streams.
interface axis_traffic_endpoint_if #(
   parameter int TDataWidth = 32,
   parameter int TIdWidth   = 2,
   parameter int TDestWidth = 4
) ();

   // A beat transfers on a rising edge where tvalid and tready are both 1; once tvalid
   // is raised the sender keeps it and every payload field stable until that transfer.
   logic                  tvalid;
   logic                  tready;
   logic [TDataWidth-1:0] tdata;
   logic                  tlast;
   logic [TIdWidth-1:0]   tid;
   logic [TDestWidth-1:0] tdest;

   modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
   modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);

endinterface

// File: rtl/axis_traffic_checker.sv
// Receive-side checker: per-tid sequence tracking with resync and saturating counters.
module axis_traffic_checker
   import axis_traffic_pkg::*;
#(
   parameter int TDataWidth = 32,
   parameter int TIdWidth   = 2
) (
   input  logic                    clk_axis_i,
   input  logic                    rst_axis_i,
   axis_traffic_endpoint_if.slave  s_axis,
   output logic [31:0]             rx_packets_o,
   output logic [31:0]             rx_errors_o
);

   localparam int UpWidth = (TDataWidth > SeqWidth) ? TDataWidth - SeqWidth : 1;

   function automatic logic [TDataWidth-1:0] pattern(input logic [SeqWidth-1:0] s);
      logic [UpWidth+SeqWidth-1:0] full;
      full = {~UpWidth'(s), s};
      return full[TDataWidth-1:0];
   endfunction

   logic [SeqWidth-1:0] exp_q [2**TIdWidth];
   logic                tready_q;
   logic [SeqWidth-1:0] exp_cur;
   logic                hs;
   logic                match;

   assign s_axis.tready = tready_q;
   assign hs            = s_axis.tvalid & tready_q;
   assign exp_cur       = exp_q[s_axis.tid];
   assign match         = (s_axis.tdata == pattern(exp_cur));

   always_ff @(posedge clk_axis_i or posedge rst_axis_i) begin
      if (rst_axis_i) begin
         tready_q     <= 1'b0;
         rx_packets_o <= '0;
         rx_errors_o  <= '0;
         for (int i = 0; i < 2**TIdWidth; i++) exp_q[i] <= '0;
      end else begin
         tready_q <= 1'b1;
         if (hs) begin
            // A mismatch resyncs to the received counter so one glitch costs one error.
            if (match) begin
               exp_q[s_axis.tid] <= exp_cur + 1'b1;
            end else begin
               exp_q[s_axis.tid] <= s_axis.tdata[SeqWidth-1:0] + 1'b1;
               if (rx_errors_o != '1) rx_errors_o <= rx_errors_o + 1'b1;
            end
            if (s_axis.tlast && rx_packets_o != '1) rx_packets_o <= rx_packets_o + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_traffic_endpoint.sv
// Traffic endpoint: round-robin per-tid packet generator plus an independent stream checker.
module axis_traffic_endpoint
   import axis_traffic_pkg::*;
#(
   parameter int TDataWidth      = 32,
   parameter int TIdWidth        = 2,
   parameter int TDestWidth      = 4,
   parameter int NumberOfStreams = 4,
   parameter int MaxPacketLength = 16
) (
   input  logic                                   clk_axis_i,
   input  logic                                   rst_axis_i,
   input  logic                                   start_i,
   input  logic [15:0]                            packet_count_i,
   input  logic [$clog2(MaxPacketLength+1)-1:0]   packet_length_i,
   input  logic [TDestWidth-1:0]                  dest_i,
   axis_traffic_endpoint_if.master                m_axis,
   axis_traffic_endpoint_if.slave                 s_axis,
   output logic                                   busy_o,
   output logic                                   tx_done_o,
   output logic [31:0]                            rx_packets_o,
   output logic [31:0]                            rx_errors_o,
   output gen_state_e                             gen_state_o
);

   localparam int LenWidth = $clog2(MaxPacketLength+1);
   localparam int UpWidth  = (TDataWidth > SeqWidth) ? TDataWidth - SeqWidth : 1;
   localparam logic [TIdWidth-1:0] LastTid = TIdWidth'(NumberOfStreams - 1);

   function automatic logic [TDataWidth-1:0] pattern(input logic [SeqWidth-1:0] s);
      logic [UpWidth+SeqWidth-1:0] full;
      full = {~UpWidth'(s), s};
      return full[TDataWidth-1:0];
   endfunction

   gen_state_e            state_q, state_d;
   logic [15:0]           count_q, pkt_idx_q, next_pkt;
   logic [LenWidth-1:0]   len_q, beat_q, next_beat;
   logic [SeqWidth-1:0]   seq_q [2**TIdWidth];
   logic [SeqWidth-1:0]   next_seq;
   logic [TIdWidth-1:0]   tid_q, next_tid;
   logic [TDestWidth-1:0] tdest_q;
   logic [TDataWidth-1:0] tdata_q;
   logic                  tvalid_q, tlast_q;
   logic                  start_ok, hs, final_beat;

   assign start_ok   = start_i && (packet_count_i != 16'd0) && (packet_length_i != '0) &&
                       (packet_length_i <= LenWidth'(MaxPacketLength));
   assign hs         = tvalid_q & m_axis.tready;
   assign final_beat = tlast_q && (pkt_idx_q == count_q - 16'd1);

   always_ff @(posedge clk_axis_i or posedge rst_axis_i) begin
      if (rst_axis_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_ok) state_d = SEND;
         SEND:    if (hs && final_beat) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Payload of the beat that follows the current one; with one stream the next packet
   // reuses the same tid, so its counter must include the beat now completing.
   always_comb begin
      next_tid  = tid_q;
      next_beat = beat_q + 1'b1;
      next_pkt  = pkt_idx_q;
      if (tlast_q) begin
         next_beat = '0;
         next_pkt  = pkt_idx_q + 16'd1;
         next_tid  = (tid_q == LastTid) ? '0 : tid_q + 1'b1;
      end
      next_seq = (next_tid == tid_q) ? seq_q[tid_q] + 1'b1 : seq_q[next_tid];
   end

   always_ff @(posedge clk_axis_i or posedge rst_axis_i) begin
      if (rst_axis_i) begin
         count_q   <= '0;
         pkt_idx_q <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         tid_q     <= '0;
         tdest_q   <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         for (int i = 0; i < 2**TIdWidth; i++) seq_q[i] <= '0;
      end else if (state_q == IDLE && start_ok) begin
         count_q   <= packet_count_i;
         len_q     <= packet_length_i;
         tdest_q   <= dest_i;
         pkt_idx_q <= '0;
         beat_q    <= '0;
         tid_q     <= '0;
         tvalid_q  <= 1'b1;
         tlast_q   <= (packet_length_i == LenWidth'(1));
         tdata_q   <= pattern(seq_q[0]);
      end else if (state_q == SEND && hs) begin
         seq_q[tid_q] <= seq_q[tid_q] + 1'b1;
         if (final_beat) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end else begin
            tid_q     <= next_tid;
            beat_q    <= next_beat;
            pkt_idx_q <= next_pkt;
            tlast_q   <= (next_beat == len_q - LenWidth'(1));
            tdata_q   <= pattern(next_seq);
         end
      end
   end

   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tid    = tid_q;
   assign m_axis.tdest  = tdest_q;
   assign busy_o        = (state_q != IDLE);
   assign tx_done_o     = (state_q == DONE);
   assign gen_state_o   = state_q;

   axis_traffic_checker #(
      .TDataWidth (TDataWidth),
      .TIdWidth   (TIdWidth)
   ) u_checker (
      .clk_axis_i   (clk_axis_i),
      .rst_axis_i   (rst_axis_i),
      .s_axis       (s_axis),
      .rx_packets_o (rx_packets_o),
      .rx_errors_o  (rx_errors_o)
   );

endmodule

// File: tb/tb_axis_traffic_endpoint.sv
// Bench for axis_traffic_endpoint: scoreboarded loopback runs plus a single-stream wrap instance.
module tb_axis_traffic_endpoint;
   import axis_traffic_pkg::*;

   localparam int DW  = 32;
   localparam int IW  = 2;
   localparam int DSW = 4;
   localparam int NS  = 4;
   localparam int ML  = 16;
   localparam int LW  = $clog2(ML+1);
   localparam int EW  = 1 + IW + DSW + DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, rst2;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic            start, start2;
   logic [15:0]     pcount, pcount2;
   logic [LW-1:0]   plen, plen2;
   logic [DSW-1:0]  dest, dest2;
   logic            busy, tx_done, busy2, tx_done2;
   logic [31:0]     rx_pk, rx_er, rx_pk2, rx_er2;
   gen_state_e      st, st2;

   axis_traffic_endpoint_if #(.TDataWidth(DW), .TIdWidth(IW), .TDestWidth(DSW)) m_if ();
   axis_traffic_endpoint_if #(.TDataWidth(DW), .TIdWidth(IW), .TDestWidth(DSW)) s_if ();
   axis_traffic_endpoint_if #(.TDataWidth(DW), .TIdWidth(IW), .TDestWidth(DSW)) m2_if ();
   axis_traffic_endpoint_if #(.TDataWidth(DW), .TIdWidth(IW), .TDestWidth(DSW)) s2_if ();

   logic            m_ready, loop_en, inj_valid, inj_last;
   logic [DW-1:0]   inj_data;
   logic [IW-1:0]   inj_tid;
   logic [DSW-1:0]  inj_dest;

   assign m_if.tready  = m_ready;
   assign s_if.tvalid  = loop_en ? (m_if.tvalid & m_if.tready) : inj_valid;
   assign s_if.tdata   = loop_en ? m_if.tdata  : inj_data;
   assign s_if.tlast   = loop_en ? m_if.tlast  : inj_last;
   assign s_if.tid     = loop_en ? m_if.tid    : inj_tid;
   assign s_if.tdest   = loop_en ? m_if.tdest  : inj_dest;

   assign m2_if.tready = 1'b1;
   assign s2_if.tvalid = m2_if.tvalid;
   assign s2_if.tdata  = m2_if.tdata;
   assign s2_if.tlast  = m2_if.tlast;
   assign s2_if.tid    = m2_if.tid;
   assign s2_if.tdest  = m2_if.tdest;

   axis_traffic_endpoint #(
      .TDataWidth(DW), .TIdWidth(IW), .TDestWidth(DSW), .NumberOfStreams(NS), .MaxPacketLength(ML)
   ) dut (
      .clk_axis_i(clk), .rst_axis_i(rst), .start_i(start), .packet_count_i(pcount),
      .packet_length_i(plen), .dest_i(dest), .m_axis(m_if), .s_axis(s_if), .busy_o(busy),
      .tx_done_o(tx_done), .rx_packets_o(rx_pk), .rx_errors_o(rx_er), .gen_state_o(st)
   );

   axis_traffic_endpoint #(
      .TDataWidth(DW), .TIdWidth(IW), .TDestWidth(DSW), .NumberOfStreams(1), .MaxPacketLength(ML)
   ) dut_wrap (
      .clk_axis_i(clk), .rst_axis_i(rst2), .start_i(start2), .packet_count_i(pcount2),
      .packet_length_i(plen2), .dest_i(dest2), .m_axis(m2_if), .s_axis(s2_if), .busy_o(busy2),
      .tx_done_o(tx_done2), .rx_packets_o(rx_pk2), .rx_errors_o(rx_er2), .gen_state_o(st2)
   );

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
   endtask

   function automatic logic [DW-1:0] pattern(input logic [15:0] s);
      return {~s, s};
   endfunction

   // ---------------- reference model / scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   logic [15:0]   model_seq [NS];
   int            exp_rx_pk = 0;

   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < NS; i++) model_seq[i] = 16'h0;
      exp_rx_pk = 0;
   endtask

   task automatic push_run(input int count, input int len, input logic [DSW-1:0] dst);
      for (int p = 0; p < count; p++) begin
         int t = p % NS;
         for (int b = 0; b < len; b++) begin
            exp_q.push_back({(b == len - 1), IW'(t), dst, pattern(model_seq[t])});
            model_seq[t] = model_seq[t] + 16'h1;
         end
      end
      exp_rx_pk += count;
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input int count, input int len, input logic [DSW-1:0] dst);
      pcount = 16'(count);
      plen   = LW'(len);
      dest   = dst;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic start_run(input int count, input int len, input logic [DSW-1:0] dst);
      pulse_start(count, len, dst);
      if (count != 0 && len >= 1 && len <= ML) push_run(count, len, dst);
   endtask

   task automatic inject(input logic [IW-1:0] t, input logic [DW-1:0] d, input logic l);
      @(posedge clk);
      #1;
      inj_valid = 1'b1; inj_tid = t; inj_data = d; inj_last = l; inj_dest = 4'h0;
      @(posedge clk);
      #1 inj_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, m_if.tvalid, 0);
      check({tag, "_tlast"}, m_if.tlast, 0);
      check({tag, "_tdata"}, m_if.tdata, 0);
      check({tag, "_tid"}, m_if.tid, 0);
      check({tag, "_tdest"}, m_if.tdest, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_tx_done"}, tx_done, 0);
      check({tag, "_s_tready"}, s_if.tready, 0);
      check({tag, "_rx_packets"}, rx_pk, 0);
      check({tag, "_rx_errors"}, rx_er, 0);
      check({tag, "_state"}, st, IDLE);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int done_cnt = 0, done_cyc = 0, hs_cnt = 0, hs_cyc = 0;

   task automatic wait_done(input int limit);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (done_cnt == d0) fail_now("tx_done_wait");
      check("queue_drained", exp_q.size(), 0);
      check("busy_after_done", busy, 0);
   endtask

   task automatic wait_beats(input int target, input int limit);
      int n = 0;
      while (hs_cnt < target && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (hs_cnt < target) fail_now("beat_wait");
   endtask

   // ---------------- ready driver ----------------
   logic rand_ready = 1'b0;
   int   bp_hold    = 0;
   always @(posedge clk) begin
      #1;
      if (bp_hold > 0) begin
         m_ready = 1'b0;
         bp_hold--;
      end else if (rand_ready) begin
         m_ready = ($urandom_range(0, 3) != 0);
      end else begin
         m_ready = 1'b1;
      end
   end

   // ---------------- monitor for the main instance ----------------
   logic                stall_flag = 1'b0;
   logic [EW-1:0]       stall_payload;
   logic [EW-1:0]       cur, e;

   always @(negedge clk) begin
      if (!rst) begin
         cur = {m_if.tlast, m_if.tid, m_if.tdest, m_if.tdata};
         if (exp_q.size() > 0) check("tvalid_no_bubble", m_if.tvalid, 1);
         else                  check("tvalid_idle", m_if.tvalid, 0);
         if (stall_flag && m_if.tvalid) check("stall_hold", cur, stall_payload);
         stall_flag    = m_if.tvalid && !m_if.tready;
         stall_payload = cur;
         if (m_if.tvalid && m_if.tready) begin
            hs_cnt++;
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               check("beat", cur, e);
            end
         end
         if (tx_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         stall_flag = 1'b0;
      end
   end

   // ---------------- single-stream wrap instance ----------------
   logic [15:0] seq2       = 16'h0;
   logic        saw_wrap   = 1'b0;
   logic        done2      = 1'b0;
   logic        wrap_fin   = 1'b0;
   int          beats2     = 0;

   always @(negedge clk) begin
      if (!rst2 && m2_if.tvalid) begin
         check("wrap_beat", m2_if.tdata, pattern(seq2));
         if (seq2 == 16'hFFFF && m2_if.tdata[15:0] == 16'h0000) saw_wrap = 1'b1;
         if (beats2 > 0 && seq2 == 16'h0000 && m2_if.tdata[15:0] == 16'h0000) saw_wrap = 1'b1;
         seq2 = seq2 + 16'h1;
         beats2++;
      end
      if (!rst2 && tx_done2) done2 = 1'b1;
   end

   initial begin
      int n;
      rst2 = 1'b0; start2 = 1'b0; pcount2 = '0; plen2 = '0; dest2 = '0;
      #2 rst2 = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst2 = 1'b0;
      @(posedge clk);
      #1;
      pcount2 = 16'd4097; plen2 = LW'(16); dest2 = 4'h2; start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      n = 0;
      while (!done2 && n < 70000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (!done2) fail_now("wrap_done_wait");
      check("wrap_beat_count", beats2, 4097 * 16);
      check("wrap_seen", saw_wrap, 1);
      check("wrap_rx_errors", rx_er2, 0);
      check("wrap_rx_packets", rx_pk2, 4097);
      wrap_fin = 1'b1;
   end

   // ---------------- main sequence ----------------
   initial begin
      int h0, n;
      rst = 1'b0; start = 1'b0; pcount = '0; plen = '0; dest = '0;
      m_ready = 1'b1; loop_en = 1'b1;
      inj_valid = 1'b0; inj_last = 1'b0; inj_data = '0; inj_tid = '0; inj_dest = '0;
      model_reset();
      #2 rst = 1'b1;
      #2 check_reset_outputs("por");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 check("s_tready_after_reset", s_if.tready, 1);

      // loopback: 4 packets of 3 beats
      h0 = hs_cnt;
      start_run(4, 3, 4'hA);
      wait_done(100);
      check("loop_beats", hs_cnt - h0, 12);
      check("loop_done_latency", done_cyc - hs_cyc, 1);
      check("loop_rx_packets", rx_pk, 4);
      check("loop_rx_errors", rx_er, 0);

      // start pulses while a run is active must not disturb it
      start_run(3, 4, 4'h5);
      repeat (3) @(posedge clk);
      #1 pulse_start(2, 2, 4'h1);
      wait_done(200);

      // backpressure: tready low for 5 cycles mid-packet
      h0 = hs_cnt;
      start_run(2, 8, 4'h3);
      wait_beats(h0 + 3, 50);
      bp_hold = 5;
      wait_done(200);
      check("bp_rx_errors", rx_er, 0);
      check("bp_rx_packets", rx_pk, 32'(exp_rx_pk));

      // randomized runs with random tready
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         start_run($urandom_range(1, 6), $urandom_range(1, ML), DSW'($urandom_range(0, 15)));
         wait_done(2000);
      end
      rand_ready = 1'b0;
      check("rand_rx_packets", rx_pk, 32'(exp_rx_pk));
      check("rand_rx_errors", rx_er, 0);

      // illegal starts
      start_run(3, 0, 4'h7);
      start_run(0, 4, 4'h7);
      start_run(2, ML + 1, 4'h7);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 check("illegal_busy", busy, 0);
      end

      // corruption and resync on the receive side
      do_reset();
      loop_en = 1'b0;
      inject(2'd1, pattern(16'h0000), 1'b0);
      inject(2'd1, pattern(16'h0001), 1'b0);
      check("corr_clean_errors", rx_er, 0);
      inject(2'd1, pattern(16'h0005), 1'b0);
      check("corr_bad_errors", rx_er, 1);
      inject(2'd1, pattern(16'h0006), 1'b1);
      check("corr_resync_errors", rx_er, 1);
      check("corr_packets", rx_pk, 1);
      inject(2'd2, 32'h1234_0000, 1'b0);
      check("corr_upper_errors", rx_er, 2);
      inject(2'd2, pattern(16'h0001), 1'b1);
      check("corr_upper_resync", rx_er, 2);
      check("corr_packets2", rx_pk, 2);
      loop_en = 1'b1;

      // reset at beat 2 of a 5-beat packet
      h0 = hs_cnt;
      start_run(1, 5, 4'h6);
      wait_beats(h0 + 2, 50);
      @(posedge clk);
      #3 rst = 1'b1;
      model_reset();
      #1 check_reset_outputs("mid");
      h0 = done_cnt;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_no_done_pulse", done_cnt - h0, 0);
      check("mid_busy_idle", busy, 0);
      start_run(1, 2, 4'h6);
      wait_done(100);
      check("mid_rx_packets", rx_pk, 1);
      check("mid_rx_errors", rx_er, 0);

      n = 0;
      while (!wrap_fin && n < 80000) begin
         @(posedge clk);
         n++;
      end
      if (!wrap_fin) fail_now("wrap_instance_finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
